des_cbc_chain: RTL and testbench

Sequential mode controller that sits directly upstream of the combinational DES core and consumes its result. It accepts 64-bit blocks over a valid/ready handshake and applies CBC chaining: pre-XOR on encrypt, post-XOR on decrypt. It drives the core's block, key and encrypt inputs from registers, waits a configurable core latency, then registers and presents the chained output. ECB pass-through is supported per block.

---
 rtl/des_pkg.sv | 12 +
 rtl/des_cbc_chain_if.sv | 26 ++
 rtl/des_cbc_chain.sv | 100 ++++++++++
 tb/tb_des_cbc_chain.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES types: block width, block type and the CBC controller state encoding.
package des_pkg;
    localparam int BLK_W = 64;

    typedef logic [63:0] des_blk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } des_cbc_state_t;
endpackage

// File: rtl/des_cbc_chain_if.sv
// Block stream into and out of the CBC controller (valid/ready on each side).
interface des_cbc_chain_if;
    import des_pkg::*;

    logic     in_valid;
    logic     in_ready;
    des_blk_t in_data;
    des_blk_t in_key;
    logic     in_encrypt;
    logic     in_cbc;
    logic     in_first;
    des_blk_t in_iv;
    logic     out_valid;
    logic     out_ready;
    des_blk_t out_data;

    modport master (
        output in_valid, in_data, in_key, in_encrypt, in_cbc, in_first, in_iv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, in_encrypt, in_cbc, in_first, in_iv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/des_cbc_chain.sv
// CBC/ECB mode controller driving an external DES core and chaining its result.
// Define DES_CBC_BLKCNT_EN to add the blk_count completed-block counter output.
module des_cbc_chain #(
    parameter int CORE_LAT = 0,
    parameter int BLK_W    = des_pkg::BLK_W
) (
    input  logic              clk,
    input  logic              reset_n,
    des_cbc_chain_if.slave    bus,
    output des_pkg::des_blk_t core_block,
    output des_pkg::des_blk_t core_key,
    output logic              core_encrypt,
    input  des_pkg::des_blk_t core_result
`ifdef DES_CBC_BLKCNT_EN
    ,
    output logic [31:0]       blk_count
`endif
);
    import des_pkg::*;

    localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT + 1) : 1;

    des_cbc_state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [BLK_W-1:0] chain_q, chain_src, mask_q, data_q, out_data_q;
    logic             cbc_q;
    logic             accept, capture, done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nxt = CALC;
            CALC:    if (cnt == '0)     state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // out_valid decodes the registered state, so there is no out_ready -> in_ready path
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == HOLD);
        accept        = bus.in_valid && (state == IDLE);
        capture       = (state == CALC) && (cnt == '0);
        done          = (state == HOLD) && bus.out_ready;
    end

    assign chain_src    = bus.in_first ? bus.in_iv : chain_q;
    assign bus.out_data = out_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_block   <= '0;
            core_key     <= '0;
            core_encrypt <= 1'b0;
            mask_q       <= '0;
            data_q       <= '0;
            cbc_q        <= 1'b0;
            cnt          <= '0;
            out_data_q   <= '0;
            chain_q      <= '0;
        end else begin
            if (accept) begin
                core_block   <= (bus.in_encrypt && bus.in_cbc) ? (bus.in_data ^ chain_src) : bus.in_data;
                mask_q       <= (!bus.in_encrypt && bus.in_cbc) ? chain_src : '0;
                core_key     <= bus.in_key;
                core_encrypt <= bus.in_encrypt;
                data_q       <= bus.in_data;
                cbc_q        <= bus.in_cbc;
                cnt          <= CNT_W'(CORE_LAT);
            end else if ((state == CALC) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            // the chain always carries the ciphertext, whichever direction produced it
            if (capture) begin
                out_data_q <= core_result ^ mask_q;
                if (cbc_q) chain_q <= core_encrypt ? core_result : data_q;
            end
        end
    end

`ifdef DES_CBC_BLKCNT_EN
    logic first_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_q   <= 1'b0;
            blk_count <= '0;
        end else begin
            if (accept) first_q <= bus.in_first;
            if (done)   blk_count <= first_q ? 32'd1 : blk_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_des_cbc_chain.sv
// Bench for des_cbc_chain: DES reference core, vector table plus scoreboard, LAT=0 and LAT=3 instances.
module tb_des_cbc_chain;
    import des_pkg::*;

    localparam int IP_T[64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP_T[64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int E_T[48]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T[32]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                 41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHF_T[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX_T[512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic des_blk_t des_fn(input des_blk_t key, input des_blk_t blk, input logic enc);
        logic [55:0] k56, cd;
        logic [27:0] c, d;
        logic [47:0] sk[16];
        logic [47:0] e;
        logic [63:0] ip, pre, res;
        logic [31:0] l, r, t, s, f;
        logic [5:0]  six;
        int          row, col;
        for (int i = 0; i < 56; i++) k56[55-i] = key[64-PC1_T[i]];
        c = k56[55:28];
        d = k56[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < SHF_T[n]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sk[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) ip[63-i] = blk[64-IP_T[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ (enc ? sk[n] : sk[15-n]);
            for (int j = 0; j < 8; j++) begin
                six = e[47-6*j -: 6];
                row = int'({six[5], six[0]});
                col = int'(six[4:1]);
                s[31-4*j -: 4] = 4'(SBOX_T[j*64 + row*16 + col]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

    typedef struct {
        des_blk_t data, key, iv, exp;
        logic     enc, cbc, first, use_model;
    } vec_t;

    function automatic vec_t mk(des_blk_t data, des_blk_t key, des_blk_t iv, logic enc, logic cbc,
                                logic first, des_blk_t exp, logic use_model);
        vec_t v;
        v.data = data; v.key = key; v.iv = iv; v.enc = enc; v.cbc = cbc;
        v.first = first; v.exp = exp; v.use_model = use_model;
        return v;
    endfunction

    logic     clk = 1'b0;
    logic     reset_n;
    des_blk_t core_block0, core_key0, core_result0;
    des_blk_t core_block1, core_key1, core_result1;
    logic     core_encrypt0, core_encrypt1;
    des_blk_t pipe1[3];
`ifdef DES_CBC_BLKCNT_EN
    logic [31:0] blk_count0, blk_count1;
    logic [31:0] bc0 = '0, bc1 = '0;
`endif

    des_cbc_chain_if bus0();
    des_cbc_chain_if bus1();

    always #5 clk = ~clk;

    des_cbc_chain #(.CORE_LAT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .core_block(core_block0), .core_key(core_key0), .core_encrypt(core_encrypt0),
        .core_result(core_result0)
`ifdef DES_CBC_BLKCNT_EN
        , .blk_count(blk_count0)
`endif
    );

    des_cbc_chain #(.CORE_LAT(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .core_block(core_block1), .core_key(core_key1), .core_encrypt(core_encrypt1),
        .core_result(core_result1)
`ifdef DES_CBC_BLKCNT_EN
        , .blk_count(blk_count1)
`endif
    );

    // combinational core for dut0; a 3-deep pipelined core for dut1 so early capture reads stale data
    assign core_result0 = des_fn(core_key0, core_block0, core_encrypt0);
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pipe1 <= '{default: '0};
        else begin
            pipe1[0] <= des_fn(core_key1, core_block1, core_encrypt1);
            pipe1[1] <= pipe1[0];
            pipe1[2] <= pipe1[1];
        end
    end
    assign core_result1 = pipe1[2];

    int       n_vec = 0, n_err = 0;
    des_blk_t sb0[$], sb1[$];
    des_blk_t mchain0 = '0, mchain1 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input vec_t v, inout des_blk_t chain, output des_blk_t exp, output des_blk_t cb);
        des_blk_t src;
        src = v.first ? v.iv : chain;
        if (v.cbc && v.enc) begin
            cb = v.data ^ src; exp = des_fn(v.key, cb, 1'b1); chain = exp;
        end else if (v.cbc) begin
            cb = v.data; exp = des_fn(v.key, v.data, 1'b0) ^ src; chain = v.data;
        end else begin
            cb = v.data; exp = des_fn(v.key, v.data, v.enc);
        end
        if (!v.use_model) exp = v.exp;
    endtask

    task automatic pop_chk(input string name, input des_blk_t act, inout des_blk_t q[$]);
        if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: output %h with empty scoreboard", name, act);
        end else chk(name, act, q.pop_front());
    endtask

    // hold > 0 keeps out_ready low that many cycles while a competing block sits on the input
    task automatic apply0(input vec_t v, input int hold);
        des_blk_t exp, cb;
        int       n;
        model(v, mchain0, exp, cb);
        @(negedge clk);
        n = 0;
        while (!bus0.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_before", 64'(bus0.in_ready), 64'd1);
        bus0.in_data = v.data; bus0.in_key = v.key; bus0.in_iv = v.iv;
        bus0.in_encrypt = v.enc; bus0.in_cbc = v.cbc; bus0.in_first = v.first;
        bus0.in_valid = 1'b1; bus0.out_ready = (hold == 0);
        @(posedge clk);
        sb0.push_back(exp);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("core_block", core_block0, cb);
        chk("core_key", core_key0, v.key);
        chk("core_encrypt", 64'(core_encrypt0), 64'(v.enc));
        chk("in_ready_busy", 64'(bus0.in_ready), 64'd0);
        n = 0;
        while (!bus0.out_valid && n < 20) begin @(negedge clk); n++; end
        chk("latency", 64'(n), 64'd1);
        for (int h = 0; h < hold; h++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = ~v.data;
            chk("bp_out_valid", 64'(bus0.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus0.in_ready), 64'd0);
            chk("bp_out_data", bus0.out_data, exp);
            @(negedge clk);
        end
        bus0.out_ready = 1'b1;
        pop_chk("out_data", bus0.out_data, sb0);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("out_valid_drop", 64'(bus0.out_valid), 64'd0);
        chk("in_ready_after", 64'(bus0.in_ready), 64'd1);
        chk("core_block_held", core_block0, cb);
`ifdef DES_CBC_BLKCNT_EN
        bc0 = v.first ? 32'd1 : bc0 + 32'd1;
        chk("blk_count0", 64'(blk_count0), 64'(bc0));
`endif
    endtask

    task automatic apply1(input vec_t v);
        des_blk_t exp, cb;
        int       n;
        model(v, mchain1, exp, cb);
        @(negedge clk);
        n = 0;
        while (!bus1.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("lat3_in_ready", 64'(bus1.in_ready), 64'd1);
        bus1.in_data = v.data; bus1.in_key = v.key; bus1.in_iv = v.iv;
        bus1.in_encrypt = v.enc; bus1.in_cbc = v.cbc; bus1.in_first = v.first;
        bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        @(posedge clk);
        sb1.push_back(exp);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            chk("lat3_core_block", core_block1, cb);
            @(negedge clk);
            n++;
        end
        chk("lat3_latency", 64'(n), 64'd4);
        pop_chk("lat3_out_data", bus1.out_data, sb1);
        @(negedge clk);
        chk("lat3_out_valid_drop", 64'(bus1.out_valid), 64'd0);
`ifdef DES_CBC_BLKCNT_EN
        bc1 = v.first ? 32'd1 : bc1 + 32'd1;
        chk("blk_count1", 64'(blk_count1), 64'(bc1));
`endif
    endtask

    localparam des_blk_t K  = 64'h133457799BBCDFF1;
    localparam des_blk_t K2 = 64'h0E329232EA6D0D73;
    localparam des_blk_t PT = 64'h0123456789ABCDEF;
    localparam des_blk_t C1 = 64'h85E813540F0AB405;

    vec_t tv[10];

    initial begin
        des_blk_t c2;
        reset_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_key = '0; bus0.in_iv = '0;
        bus0.in_encrypt = 1'b0; bus0.in_cbc = 1'b0; bus0.in_first = 1'b0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_key = '0; bus1.in_iv = '0;
        bus1.in_encrypt = 1'b0; bus1.in_cbc = 1'b0; bus1.in_first = 1'b0; bus1.out_ready = 1'b1;

        c2 = des_fn(K, 64'h84CB563386A179EA, 1'b1);
        tv[0] = mk(PT, K, '1, 1'b1, 1'b0, 1'b1, C1, 1'b0);
        tv[1] = mk(PT, K, '0, 1'b1, 1'b1, 1'b1, C1, 1'b0);
        tv[2] = mk(PT, K, '0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        tv[3] = mk(C1, K, '0, 1'b0, 1'b1, 1'b1, PT, 1'b0);
        tv[4] = mk(c2, K, 64'h5555AAAA5555AAAA, 1'b0, 1'b1, 1'b0, PT, 1'b0);
        tv[5] = mk(C1, K, '0, 1'b0, 1'b0, 1'b0, PT, 1'b0);
        tv[6] = mk(64'hA5A5A5A5A5A5A5A5, K, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        tv[7] = mk(64'h1122334455667788, K2, 64'h0F1E2D3C4B5A6978, 1'b1, 1'b1, 1'b1, '0, 1'b1);
        tv[8] = mk(64'hDEADBEEFCAFEF00D, K2, '1, 1'b1, 1'b0, 1'b1, '0, 1'b1);
        tv[9] = mk(64'h0011223344556677, K2, 64'h123456789ABCDEF0, 1'b1, 1'b1, 1'b0, '0, 1'b1);

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_out_data", bus0.out_data, '0);
        chk("rst_core_block", core_block0, '0);
        chk("rst_core_key", core_key0, '0);
        chk("rst_core_encrypt", 64'(core_encrypt0), 64'd0);
`ifdef DES_CBC_BLKCNT_EN
        chk("rst_blk_count", 64'(blk_count0), 64'd0);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply0(tv[i], 0);
            if (i == 2) chk("cbc2_core_block", core_block0, 64'h84CB563386A179EA);
        end

        // backpressure: out_ready low for 5 cycles with another block waiting
        apply0(mk(64'h0badc0de0badc0de, K, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1), 5);

        apply1(mk(PT, K, 64'hFEDCBA9876543210, 1'b1, 1'b1, 1'b1, '0, 1'b1));
        apply1(mk(64'h7766554433221100, K, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1));

        // reset while dut1 is mid-CALC; the in-flight block must vanish
        @(negedge clk);
        bus1.in_data = PT; bus1.in_key = K; bus1.in_iv = 64'hAAAAAAAAAAAAAAAA;
        bus1.in_encrypt = 1'b1; bus1.in_cbc = 1'b1; bus1.in_first = 1'b1; bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mchain0 = '0; mchain1 = '0;
        chk("midrst_out_valid", 64'(bus1.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus1.in_ready), 64'd1);
        chk("midrst_core_block", core_block1, '0);
        chk("midrst_out_data", bus1.out_data, '0);
`ifdef DES_CBC_BLKCNT_EN
        chk("midrst_blk_count", 64'(blk_count1), 64'd0);
        bc0 = '0; bc1 = '0;
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_output", 64'(bus1.out_valid), 64'd0);
        end
        apply1(mk(PT, K, 64'h0F0F0F0F0F0F0F0F, 1'b1, 1'b1, 1'b1, '0, 1'b1));
        apply1(mk(PT, K, 64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b1, 1'b0, '0, 1'b1));
        apply0(mk(PT, K, '0, 1'b1, 1'b1, 1'b0, '0, 1'b1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
